// File: rtl/counter_ctrl_frontend_pkg.sv
// Shared definitions for the mod-N counter command path: ctrl codes, run modes
// and small helpers used by the front end and the counter itself.
package counter_ctrl_frontend_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_UP     = 2'd1,
        MODE_DOWN   = 2'd2,
        MODE_UPDOWN = 2'd3
    } mode_t;

    localparam logic [2:0] CTRL_HOLD   = 3'b000;
    localparam logic [2:0] CTRL_UP     = 3'b001;
    localparam logic [2:0] CTRL_DOWN   = 3'b010;
    localparam logic [2:0] CTRL_UPDOWN = 3'b011;
    localparam logic [2:0] CTRL_LOAD   = 3'b100;
    localparam logic [2:0] CTRL_CLEAR  = 3'b101;

    function automatic logic [3:0] sat_load(input logic [3:0] value, input logic [3:0] max_value);
        if (value > max_value) begin
            return max_value;
        end else begin
            return value;
        end
    endfunction

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_HOLD:   return MODE_UP;
            MODE_UP:     return MODE_DOWN;
            MODE_DOWN:   return MODE_UPDOWN;
            MODE_UPDOWN: return MODE_HOLD;
            default:     return MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_frontend_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, consecutive-sample filter and
// a registered one-clock pulse on each accepted press (releases are silent).
module btn_debounce #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, filter and detect the rising edge of the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            if (sync2_r != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= sync2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                // Any sample agreeing with the accepted level restarts the filter.
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/counter_ctrl_frontend.sv
// Command front end for the mod-N counter: debounced buttons drive the run mode
// and load/clear one-shots that stay pending until a clk_en edge consumes them.
module counter_ctrl_frontend
    import counter_ctrl_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MOD_N           = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       btn_mode_raw,
    input  logic       btn_load_raw,
    input  logic       btn_clr_raw,
    input  logic [3:0] sw_raw,
    output logic [2:0] ctrl,
    output logic [3:0] inp,
    output logic [1:0] mode,
    output logic       cmd_busy
);

    localparam logic [3:0] LOAD_MAX = 4'(MOD_N - 1);

    logic       mode_press_s;
    logic       load_press_s;
    logic       clr_press_s;
    logic [3:0] sw_sync1_r;
    logic [3:0] sw_sync2_r;
    mode_t      mode_r;
    logic       clr_pend_r;
    logic       ld_pend_r;
    logic [3:0] inp_r;
    logic [2:0] ctrl_r;
    logic       cmd_busy_r;
    mode_t      mode_next_s;
    logic       clr_next_s;
    logic       ld_next_s;
    logic [3:0] inp_next_s;
    logic [2:0] ctrl_next_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode_raw),
        .press (mode_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_load_raw),
        .press (load_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clr_raw),
        .press (clr_press_s)
    );

    // Switch bank synchroniser; the value is only sampled on a load press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_r <= 4'd0;
            sw_sync2_r <= 4'd0;
        end else begin
            sw_sync1_r <= sw_raw;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    // Next mode, pending flags, load value and the ctrl code they imply.
    always_comb begin
        mode_next_s = mode_r;
        clr_next_s  = clr_pend_r;
        ld_next_s   = ld_pend_r;
        inp_next_s  = inp_r;
        ctrl_next_s = CTRL_HOLD;

        if (mode_press_s) begin
            mode_next_s = next_mode(mode_r);
        end else begin
            mode_next_s = mode_r;
        end

        if (clr_press_s) begin
            // Clear wins over a same-cycle load and cancels any pending load.
            clr_next_s = 1'b1;
            ld_next_s  = 1'b0;
            inp_next_s = inp_r;
        end else begin
            clr_next_s = (clk_en && (ctrl_r == CTRL_CLEAR)) ? 1'b0 : clr_pend_r;
            if (load_press_s && !clr_pend_r) begin
                ld_next_s  = 1'b1;
                inp_next_s = sat_load(sw_sync2_r, LOAD_MAX);
            end else begin
                ld_next_s  = (clk_en && (ctrl_r == CTRL_LOAD)) ? 1'b0 : ld_pend_r;
                inp_next_s = inp_r;
            end
        end

        if (clr_next_s) begin
            ctrl_next_s = CTRL_CLEAR;
        end else if (ld_next_s) begin
            ctrl_next_s = CTRL_LOAD;
        end else begin
            ctrl_next_s = {1'b0, mode_next_s};
        end
    end

    // Mode FSM and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r     <= MODE_HOLD;
            clr_pend_r <= 1'b0;
            ld_pend_r  <= 1'b0;
            inp_r      <= 4'd0;
            ctrl_r     <= CTRL_HOLD;
            cmd_busy_r <= 1'b0;
        end else begin
            mode_r     <= mode_next_s;
            clr_pend_r <= clr_next_s;
            ld_pend_r  <= ld_next_s;
            inp_r      <= inp_next_s;
            ctrl_r     <= ctrl_next_s;
            cmd_busy_r <= clr_next_s | ld_next_s;
        end
    end

    assign ctrl     = ctrl_r;
    assign inp      = inp_r;
    assign mode     = mode_r;
    assign cmd_busy = cmd_busy_r;

endmodule
